uart_tx_io: RTL

Memory-mapped UART transmitter peripheral for the Minisys CPU's IO space. It is the send-side counterpart of the UART receive path used for program loading. The CPU writes bytes through the MemOrIO IO-write path into a small TX FIFO. The block serializes each byte as 8N1 onto a tx pin, and the CPU polls a status word through the IO-read path.

---
 rtl/uart_tx_io.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_io.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_io
//  Purpose  : Memory-mapped 8N1 UART transmitter for the Minisys IO space.
//             The CPU stores bytes into a small TX FIFO through the IO-write
//             path. The block serialises them onto the tx pin and exposes a
//             pollable STATUS word on the IO-read path.
//  Ports    : clock    - CPU clock, rising edge
//             reset    - synchronous, active-high reset
//             io_write - IO store strobe (one cycle per store)
//             io_read  - IO load strobe (one cycle per load)
//             addr_sel - 0 = TXDATA, 1 = STATUS
//             wdata    - byte to transmit (TXDATA stores only)
//             rdata    - read data, combinational from current state
//             tx       - serial line, registered, idle high
//             tx_busy  - frame on the line or FIFO not empty
//  STATUS   : {24'b0, count[3:0], overflow, tx_busy, empty, full}
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_io #(
    parameter int CLK_FREQ_HZ = 23000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_write,
    input  logic        io_read,
    input  logic        addr_sel,
    input  logic [7:0]  wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        tx_busy
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int C_BAUD_DIV = CLK_FREQ_HZ / BAUD;
    localparam int C_BCW      = (C_BAUD_DIV > 1) ? $clog2(C_BAUD_DIV) : 1;
    localparam int C_PW       = $clog2(FIFO_DEPTH);
    localparam int C_CW       = C_PW + 1;

    localparam logic [C_BCW-1:0] C_BAUD_RELOAD = C_BCW'(C_BAUD_DIV - 1);
    localparam logic [C_CW-1:0]  C_DEPTH       = C_CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t            r_state;
    logic              r_tx;
    logic [7:0]        r_shift;
    logic [C_BCW-1:0]  r_baud_cnt;
    logic [2:0]        r_bit_idx;

    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [C_PW-1:0]   r_wr_ptr;
    logic [C_PW-1:0]   r_rd_ptr;
    logic [C_CW-1:0]   r_count;
    logic              r_overflow;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic        w_empty;
    logic        w_full;
    logic        w_baud_done;
    logic        w_pop;
    logic        w_wr_req;
    logic        w_push;
    logic        w_status_rd;
    logic [7:0]  w_head;
    logic [4:0]  w_cnt_ext;
    logic [3:0]  w_cnt_sat;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == C_DEPTH);
    assign w_baud_done = (r_baud_cnt == '0);
    assign w_head      = r_mem[r_rd_ptr];

    // The FSM takes the FIFO head either from idle, or at the very end of a
    // stop bit so consecutive frames run with no idle gap.
    assign w_pop = !w_empty &&
                   ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_done));

    // A store to a full FIFO still lands if the FSM frees a slot on the same
    // edge; otherwise the byte is dropped and flagged.
    assign w_wr_req    = io_write && !addr_sel;
    assign w_push      = w_wr_req && (!w_full || w_pop);
    assign w_status_rd = io_read && addr_sel;

    // ------------------------------------------------------------------------
    // TX FIFO: pointers wrap naturally because the depth is a power of two.
    // Storage is not reset; clearing the pointers and count discards it.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CW'(1);
                2'b01:   r_count <= r_count - C_CW'(1);
                default: r_count <= r_count;
            endcase
            // Sticky overflow; a dropped store beats a clearing STATUS read.
            if (w_wr_req && !w_push) begin
                r_overflow <= 1'b1;
            end else if (w_status_rd) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Serialiser FSM. The baud counter is loaded with BAUD_DIV-1 whenever a
    // new bit is driven, so each bit lasts exactly BAUD_DIV cycles.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_tx       <= 1'b1;
            r_shift    <= 8'h00;
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift    <= w_head;
                        r_baud_cnt <= C_BAUD_RELOAD;
                        r_tx       <= 1'b0;
                        r_state    <= S_START;
                    end
                end

                S_START: begin
                    if (w_baud_done) begin
                        r_tx       <= r_shift[0];
                        r_shift    <= {1'b0, r_shift[7:1]};
                        r_bit_idx  <= 3'd0;
                        r_baud_cnt <= C_BAUD_RELOAD;
                        r_state    <= S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt - C_BCW'(1);
                    end
                end

                S_DATA: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= C_BAUD_RELOAD;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt - C_BCW'(1);
                    end
                end

                S_STOP: begin
                    if (w_baud_done) begin
                        if (w_pop) begin
                            r_shift    <= w_head;
                            r_baud_cnt <= C_BAUD_RELOAD;
                            r_tx       <= 1'b0;
                            r_state    <= S_START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt - C_BCW'(1);
                    end
                end

                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign tx      = r_tx;
    assign tx_busy = (r_state != S_IDLE) || !w_empty;

    // Count field is four bits wide; a 16-deep FIFO saturates it at 15.
    assign w_cnt_ext = 5'(r_count);
    assign w_cnt_sat = w_cnt_ext[4] ? 4'hF : w_cnt_ext[3:0];

    assign rdata = addr_sel ? {24'b0, w_cnt_sat, r_overflow, tx_busy, w_empty, w_full}
                            : 32'b0;

endmodule
`default_nettype wire
